// File: rtl/csr_trap_seq.sv
// ECALL/MRET trap sequencer: issues ordered CSR accesses over a valid/ready port and
// hands the resulting target PC to IFU. Optional mstatus RMW via CSR_TRAP_MSTATUS_EN.
module csr_trap_seq #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] CAUSE_ECALL = ADDR_W'(32'h0000_000b),
  parameter int                TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trap_valid_i,
  output logic              trap_ready_o,
  input  logic [1:0]        trap_op_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              csr_valid_o,
  input  logic              csr_ready_i,
  output logic              csr_we_o,
  output logic [11:0]       csr_addr_o,
  output logic [ADDR_W-1:0] csr_wdata_o,
  input  logic [ADDR_W-1:0] csr_rdata_i,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  input  logic              redirect_ready_i,
  output logic              err_o
);

  localparam int                CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [11:0]       A_MSTATUS  = 12'h300;
  localparam logic [11:0]       A_MTVEC    = 12'h305;
  localparam logic [11:0]       A_MEPC     = 12'h341;
  localparam logic [11:0]       A_MCAUSE   = 12'h342;
  localparam logic [1:0]        OP_ECALL   = 2'b01;
  localparam logic [1:0]        OP_MRET    = 2'b10;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [2:0] {
    S_IDLE, S_W_EPC, S_W_CAUSE, S_R_VEC, S_R_EPC, S_REDIR
`ifdef CSR_TRAP_MSTATUS_EN
    , S_R_MST, S_W_MST
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

`ifdef CSR_TRAP_MSTATUS_EN
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] mst_q, mst_d;
  logic [ADDR_W-1:0] mst_trap, mst_ret;

  // mstatus bits: MIE[3], MPIE[7], MPP[12:11]
  always_comb begin
    mst_trap        = mst_q;
    mst_trap[7]     = mst_q[3];
    mst_trap[3]     = 1'b0;
    mst_trap[12:11] = 2'b11;
    mst_ret         = mst_q;
    mst_ret[3]      = mst_q[7];
    mst_ret[7]      = 1'b1;
    mst_ret[12:11]  = 2'b11;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef CSR_TRAP_MSTATUS_EN
      op_q    <= '0;
      mst_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef CSR_TRAP_MSTATUS_EN
      op_q    <= op_d;
      mst_q   <= mst_d;
`endif
    end
  end

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    tgt_d            = tgt_q;
    cnt_d            = '0;
    err_d            = 1'b0;
`ifdef CSR_TRAP_MSTATUS_EN
    op_d             = op_q;
    mst_d            = mst_q;
`endif
    csr_valid_o      = 1'b0;
    csr_we_o         = 1'b0;
    csr_addr_o       = '0;
    csr_wdata_o      = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;

    case (state_q)
      S_IDLE: begin
        if (trap_valid_i) begin
          pc_d = pc_i;
`ifdef CSR_TRAP_MSTATUS_EN
          op_d = trap_op_i;
`endif
          if (trap_op_i == OP_ECALL) state_d = S_W_EPC;
          else if (trap_op_i == OP_MRET)
`ifdef CSR_TRAP_MSTATUS_EN
            state_d = S_R_MST;
`else
            state_d = S_R_EPC;
`endif
        end
      end
      S_W_EPC: begin
        csr_valid_o = 1'b1;
        csr_we_o    = 1'b1;
        csr_addr_o  = A_MEPC;
        csr_wdata_o = pc_q;
        if (csr_ready_i) state_d = S_W_CAUSE;
      end
      S_W_CAUSE: begin
        csr_valid_o = 1'b1;
        csr_we_o    = 1'b1;
        csr_addr_o  = A_MCAUSE;
        csr_wdata_o = CAUSE_ECALL;
        if (csr_ready_i)
`ifdef CSR_TRAP_MSTATUS_EN
          state_d = S_R_MST;
`else
          state_d = S_R_VEC;
`endif
      end
      // Targets are forced word-aligned: direct-mode mtvec, aligned mepc.
      S_R_VEC: begin
        csr_valid_o = 1'b1;
        csr_addr_o  = A_MTVEC;
        if (csr_ready_i) begin
          tgt_d   = csr_rdata_i & ALIGN_MASK;
          state_d = S_REDIR;
        end
      end
      S_R_EPC: begin
        csr_valid_o = 1'b1;
        csr_addr_o  = A_MEPC;
        if (csr_ready_i) begin
          tgt_d   = csr_rdata_i & ALIGN_MASK;
          state_d = S_REDIR;
        end
      end
`ifdef CSR_TRAP_MSTATUS_EN
      S_R_MST: begin
        csr_valid_o = 1'b1;
        csr_addr_o  = A_MSTATUS;
        if (csr_ready_i) begin
          mst_d   = csr_rdata_i;
          state_d = S_W_MST;
        end
      end
      S_W_MST: begin
        csr_valid_o = 1'b1;
        csr_we_o    = 1'b1;
        csr_addr_o  = A_MSTATUS;
        csr_wdata_o = (op_q == OP_ECALL) ? mst_trap : mst_ret;
        if (csr_ready_i) state_d = (op_q == OP_ECALL) ? S_R_VEC : S_R_EPC;
      end
`endif
      S_REDIR: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = tgt_q;
        if (redirect_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Counter is zero on entry to every CSR state; only stalled cycles count.
    if (csr_valid_o && !csr_ready_i) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign trap_ready_o = reset && (state_q == S_IDLE);
  assign err_o        = err_q;

endmodule

// File: doc/csr_trap_seq.md
Name: csr_trap_seq

Overview:
- Sequential trap initiator for the registered CSR file.
- Accepts ECALL/MRET requests from IDU and performs the required CSR accesses one at a time over a valid/ready CSR port: on ECALL writes mepc and mcause, then reads mtvec; on MRET reads mepc.
- Hands the resulting target PC to IFU as a redirect.
- Replaces direct combinational CSR side-effects with ordered, handshaked transactions.

Parameters:
- ADDR_W, 32, PC and CSR data width.
- CAUSE_ECALL, 32'h0000_000b, mcause value written on ECALL from M-mode.
- TIMEOUT, 16, max cycles csr_valid_o may wait for csr_ready_i before abort.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = asserted).
- trap_valid_i  in  1  IDU trap request valid.
- trap_ready_o  out  1  sequencer idle and able to accept.
- trap_op_i  in  2  01 = ECALL, 10 = MRET; other values are ignored (accepted, no action).
- pc_i  in  ADDR_W  PC of the trapping instruction.
- csr_valid_o  out  1  CSR access request valid.
- csr_ready_i  in  1  CSR file accepts; for reads, csr_rdata_i is valid in the same cycle.
- csr_we_o  out  1  1 = write, 0 = read.
- csr_addr_o  out  12  CSR address (mstatus 300, mtvec 305, mepc 341, mcause 342, hex).
- csr_wdata_o  out  ADDR_W  write data.
- csr_rdata_i  in  ADDR_W  read data.
- redirect_valid_o  out  1  target PC valid to IFU.
- redirect_pc_o  out  ADDR_W  target PC.
- redirect_ready_i  in  1  IFU accepts redirect.
- err_o  out  1  one-cycle pulse on CSR timeout abort.

Behaviour:
- Reset (asynchronous, reset = 0):
  - State = IDLE.
  - All outputs 0, except trap_ready_o = 1 once reset deasserts.
  - Latched pc, op and target cleared; timeout counter cleared.
- Handshakes:
  - A transfer occurs on a rising edge where valid && ready.
  - valid outputs and their payload stay stable until accepted.
  - The sequencer never drops csr_valid_o or redirect_valid_o without acceptance, except on timeout abort.
- States:
  - IDLE: trap_ready_o = 1. On trap_valid_i:
    - Latch pc_i and trap_op_i.
    - ECALL -> W_EPC; MRET -> R_EPC; other op -> IDLE.
  - W_EPC: write mepc = latched pc; on accept -> W_CAUSE.
  - W_CAUSE: write mcause = CAUSE_ECALL; on accept -> R_VEC.
  - R_VEC: read mtvec; on accept latch csr_rdata_i into target -> REDIR.
  - R_EPC: read mepc; on accept latch target -> REDIR.
  - REDIR: redirect_valid_o = 1, redirect_pc_o = target; on redirect_ready_i -> IDLE.
- Latency with all readys held high:
  - ECALL: redirect_valid_o asserts 4 cycles after acceptance.
  - MRET: redirect_valid_o asserts 2 cycles after acceptance.
- trap_ready_o is 0 in every state except IDLE. A new request is accepted no earlier than the cycle after redirect acceptance.
- Timeout:
  - Counter resets on entry to each CSR state and increments each cycle csr_valid_o && !csr_ready_i.
  - On reaching TIMEOUT: drop csr_valid_o, pulse err_o for one cycle, go to IDLE, no redirect.
  - The REDIR state has no timeout.
- Target PC: bits [1:0] of target forced to 00 (mtvec direct mode; mepc alignment).
- Reset asserted mid-sequence: immediate return to IDLE; partial CSR writes are not rolled back.
- csr_wdata_o = 0 and csr_we_o = 0 whenever csr_valid_o = 0.

Optional Feature:
- Macro: CSR_TRAP_MSTATUS_EN.
- Defined: an extra read-modify-write of mstatus.
  - ECALL: after W_CAUSE -> R_MST (read mstatus) -> W_MST, writing MPIE = MIE, MIE = 0, MPP = 2'b11, then -> R_VEC. ECALL latency becomes 6 cycles.
  - MRET: R_MST -> W_MST, writing MIE = MPIE, MPIE = 1, MPP = 2'b11, then -> R_EPC. MRET latency becomes 4 cycles.
  - Timeout applies to both new states.
- Undefined: R_MST and W_MST are absent and mstatus is never accessed.

Test Plan:
- ECALL, pc_i = 8000_0010, mtvec model = 8000_0100, all readys 1 -> writes 341 <= 8000_0010, then 342 <= 0000_000b, then read 305; redirect_pc_o = 8000_0100 four cycles after acceptance; trap_ready_o = 0 throughout.
- MRET, mepc model = 8000_0014 -> single read of 341; redirect_pc_o = 8000_0014 two cycles after acceptance.
- ECALL with csr_ready_i held 0 -> csr_valid_o and address 341 stable for 16 cycles, then err_o pulses for one cycle, state returns to IDLE, redirect_valid_o never asserts.
- MRET with redirect_ready_i low for 5 cycles -> redirect_valid_o and redirect_pc_o held stable; returns to IDLE the cycle after acceptance; a second request queued during this time is accepted only then.
- reset driven to 0 during W_CAUSE -> all outputs 0 asynchronously; after release, trap_ready_o = 1 and a fresh ECALL completes normally.
- With CSR_TRAP_MSTATUS_EN, ECALL, mstatus model = 0000_0008 -> mstatus written as 0000_1880 before the mtvec read.
